// File: rtl/regarb_pkg.sv
// Shared definitions for the register-file write arbiter and its per-requester queues.
package regarb_pkg;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;
  localparam int unsigned DATA_W   = 64;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic {
    PRIO_Q0 = 1'b0,
    PRIO_Q1 = 1'b1
  } prio_e;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] addr);
    reg_onehot       = '0;
    reg_onehot[addr] = 1'b1;
  endfunction
endpackage

// File: rtl/regarb_fifo.sv
// In-order writeback queue for one requester; exposes per-entry occupancy and
// target addresses so the top can build the pending-register mask.
module regarb_fifo
  import regarb_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = regarb_pkg::DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [ADDR_W-1:0]             push_addr,
  input  logic [DATA_W-1:0]             push_data,
  output logic                          full,
  output logic                          empty,
  output logic [ADDR_W-1:0]             head_addr,
  output logic [DATA_W-1:0]             head_data,
  output logic [DEPTH-1:0]              occ,
  output logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [PTR_W:0]   CNT_MAX = DEPTH[PTR_W:0];

  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [PTR_W:0]               count;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_mem;
  logic [DATA_W-1:0]            data_mem [DEPTH];
  logic [PTR_W-1:0]             offset;

  assign full       = (count == CNT_MAX);
  assign empty      = (count == '0);
  assign head_addr  = addr_mem[rd_ptr];
  assign head_data  = data_mem[rd_ptr];
  assign entry_addr = addr_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: stale slots are masked by occ.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin
    occ    = '0;
    offset = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr;
      occ[i] = ({1'b0, offset} < count);
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges pipeline and load-unit writebacks into one register-file write port.
// Define REGARB_FIXED_PRIO_EN for strict queue-0 priority instead of round-robin.
module regfile_write_arbiter
  import regarb_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = regarb_pkg::DATA_W
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Req0Valid,
  output logic                Req0Ready,
  input  logic [ADDR_W-1:0]   Req0Addr,
  input  logic [DATA_W-1:0]   Req0Data,
  input  logic                Req1Valid,
  output logic                Req1Ready,
  input  logic [ADDR_W-1:0]   Req1Addr,
  input  logic [DATA_W-1:0]   Req1Data,
  output logic                RegWrite,
  output logic [NUM_REGS-1:0] InputSelect,
  output logic [DATA_W-1:0]   WriteData,
  output logic [NUM_REGS-1:0] PendingMask
);
  logic                         full0, empty0, full1, empty1;
  logic                         push0, push1, grant0, grant1;
  logic [ADDR_W-1:0]            head_addr0, head_addr1;
  logic [DATA_W-1:0]            head_data0, head_data1;
  logic [DEPTH-1:0]             occ0, occ1;
  logic [DEPTH-1:0][ADDR_W-1:0] addrs0, addrs1;

  assign Req0Ready = ~full0;
  assign Req1Ready = ~full1;
  // Zero-register writes complete the handshake but never enter a queue.
  assign push0 = Req0Valid & Req0Ready & (Req0Addr != ZERO_REG);
  assign push1 = Req1Valid & Req1Ready & (Req1Addr != ZERO_REG);

  regarb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_q0 (
    .clk(Clk), .rst(Reset), .push(push0), .pop(grant0),
    .push_addr(Req0Addr), .push_data(Req0Data),
    .full(full0), .empty(empty0), .head_addr(head_addr0), .head_data(head_data0),
    .occ(occ0), .entry_addr(addrs0)
  );

  regarb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_q1 (
    .clk(Clk), .rst(Reset), .push(push1), .pop(grant1),
    .push_addr(Req1Addr), .push_data(Req1Data),
    .full(full1), .empty(empty1), .head_addr(head_addr1), .head_data(head_data1),
    .occ(occ1), .entry_addr(addrs1)
  );

`ifdef REGARB_FIXED_PRIO_EN
  always_comb begin
    grant0 = ~empty0;
    grant1 = empty0 & ~empty1;
  end
`else
  prio_e prio_q, prio_d;

  always_ff @(posedge Clk) begin
    if (Reset) prio_q <= PRIO_Q0;
    else       prio_q <= prio_d;
  end

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    prio_d = prio_q;
    if (!empty0 && !empty1) begin
      if (prio_q == PRIO_Q0) grant0 = 1'b1;
      else                   grant1 = 1'b1;
    end else begin
      grant0 = ~empty0;
      grant1 = ~empty1;
    end
    if (grant0)      prio_d = PRIO_Q1;
    else if (grant1) prio_d = PRIO_Q0;
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      RegWrite    <= 1'b0;
      InputSelect <= '0;
      WriteData   <= '0;
    end else begin
      RegWrite    <= grant0 | grant1;
      InputSelect <= '0;
      if (grant0) begin
        InputSelect <= reg_onehot(head_addr0);
        WriteData   <= head_data0;
      end else if (grant1) begin
        InputSelect <= reg_onehot(head_addr1);
        WriteData   <= head_data1;
      end
    end
  end

  always_comb begin
    PendingMask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (occ0[i]) PendingMask = PendingMask | reg_onehot(addrs0[i]);
      if (occ1[i]) PendingMask = PendingMask | reg_onehot(addrs1[i]);
    end
  end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: DEPTH, 2, entries per requester queue (power of two, >=2).
REQ-002 Parameter: DATA_W, 64, write data width.
REQ-003 Port: Clk  input  1  single clock, all state on rising edge.
REQ-004 Port: Reset  input  1  synchronous, active-high reset.
REQ-005 Port: Req0Valid / Req0Ready  input / output  1 / 1  pipeline writeback handshake.
REQ-006 Port: Req0Addr / Req0Data  input  5 / DATA_W  pipeline writeback register index and value.
REQ-007 Port: Req1Valid / Req1Ready  input / output  1 / 1  load-unit writeback handshake.
REQ-008 Port: Req1Addr / Req1Data  input  5 / DATA_W  load-unit register index and value.
REQ-009 Port: RegWrite  output  1  register-file write strobe.
REQ-010 Port: InputSelect  output  32  one-hot register select, bit i = register i.
REQ-011 Port: WriteData  output  DATA_W  register-file write value.
REQ-012 Port: PendingMask  output  32  bit i set while any queued, unwritten entry targets register i.

Function
REQ-013 Transfer on ReqNValid & ReqNReady at rising Clk; ReqNReady SHALL equal "queue N not full", independent of ReqNValid.
REQ-014 Accepted entry with Addr != 31 SHALL enqueue in order into queue N; Addr == 31 (zero register) SHALL be accepted and discarded, never written, never pending.
REQ-015 Each cycle, arbiter SHALL pop exactly one non-empty queue head (or none if both empty) and register it to outputs.
REQ-016 Registered outputs: RegWrite=1, InputSelect=one-hot(addr), WriteData=data in cycle after pop; otherwise RegWrite=0, InputSelect=0, WriteData holds last value.
REQ-017 Latency: entry accepted at edge N into an empty queue with no contention SHALL appear on write outputs after edge N+1.
REQ-018 InputSelect SHALL never have more than one bit set and SHALL be zero whenever RegWrite=0.
REQ-019 Default arbitration round-robin: after granting queue k, queue 1-k has priority next cycle when both non-empty; single non-empty queue always granted.
REQ-020 Order within one requester SHALL be preserved; across requesters, same-address writes occur in grant order.
REQ-021 Simultaneous push and pop on a full queue: pop frees slot only from next cycle (Ready stays 0 that cycle).
REQ-022 PendingMask SHALL be combinational OR of one-hot addresses of all valid queue entries; bit 31 SHALL always be 0.
REQ-023 Pointer wrap-around modulo DEPTH; occupancy counter width clog2(DEPTH)+1.

Reset
REQ-024 Reset SHALL empty both queues, set RegWrite=0, InputSelect=0, WriteData=0, priority to queue 0.
REQ-025 Reset mid-operation SHALL discard queued entries; no write issues in the cycle following a Reset edge; Ready outputs return to 1 in the cycle after Reset deasserts.
REQ-026 Handshakes presented during Reset SHALL be ignored.

Configuration
REQ-027 Macro REGARB_FIXED_PRIO_EN defined: queue 0 SHALL always win when non-empty (strict priority); priority state removed.
REQ-028 Macro undefined: round-robin per REQ-019.

Structure
REQ-029 Shared package regarb_pkg SHALL hold ADDR_W=5, NUM_REGS=32, ZERO_REG=31, DATA_W default, and the queue-entry struct {addr, data}.
REQ-030 Per-requester queue SHALL be one sub-module regarb_fifo (push/pop/full/empty/head, entry-occupancy vector for PendingMask), instantiated twice.

Verification
REQ-031 Single write: Req0 {addr 5, data 0xDEAD} at edge 1 -> RegWrite=1, InputSelect=0x00000020, WriteData=0xDEAD after edge 2; PendingMask bit 5 set between edges 1 and 2.
REQ-032 Contention: both queues hold 2 entries (Req0 addrs 1,2; Req1 addrs 3,4) -> write order 1,3,2,4 (round-robin); with REGARB_FIXED_PRIO_EN -> 1,2,3,4.
REQ-033 Full/backpressure: Req1 pushes 3 back-to-back while Req0 holds grant-priority traffic -> Req1Ready=0 after 2nd push, 3rd entry accepted only after a Req1 pop, none lost.
REQ-034 Zero register: Req0 {addr 31, data 0x1234} -> Req0Ready handshake completes, RegWrite stays 0, PendingMask=0.
REQ-035 Reset mid-stream: both queues full, assert Reset 1 cycle -> no RegWrite next cycle, PendingMask=0, Ready=1 after deassert.
REQ-036 Random stress: 10k cycles random Valid/addr/data vs. scoreboard model -> per-requester order preserved, one-hot InputSelect, no drops or duplicates.
